// File: rtl/stream_demux_pkg.sv
// Shared constants and types for the stream demultiplexer.
//   DefaultN / DefaultW : default channel count and payload width
//   chan_idx_t          : channel index for the default channel count
//   cnt_t               : per-channel FIFO occupancy (0..2)
package stream_demux_pkg;

  localparam int unsigned DefaultN = 4;
  localparam int unsigned DefaultW = 8;

  typedef logic [$clog2(DefaultN)-1:0] chan_idx_t;
  typedef logic [1:0]                  cnt_t;

  localparam cnt_t FifoDepth = 2'd2;

endpackage

// File: rtl/stream_demux_if.sv
// Handshake bundle of the stream demultiplexer.
//   in_valid/in_ready/in_data : input beat handshake and payload
//   in_sel                    : manual destination channel
//   auto                      : use the round-robin pointer instead of in_sel
//   out_valid/out_ready       : per-channel output handshake
//   out_data                  : per-channel payload (FIFO head)
//   err                       : one-cycle pulse after a beat to a missing channel is dropped
// master = beat producer / channel consumers; slave = the demux itself.
interface stream_demux_if
  import stream_demux_pkg::*;
#(
  parameter int unsigned N = DefaultN,
  parameter int unsigned W = DefaultW
);

  localparam int unsigned SelW = $clog2(N);

  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_data;
  logic [SelW-1:0] in_sel;
  logic            auto;
  logic [N-1:0]    out_valid;
  logic [N-1:0]    out_ready;
  logic [W-1:0]    out_data [N];
  logic            err;

  modport master (
    output in_valid, in_data, in_sel, auto, out_ready,
    input  in_ready, out_valid, out_data, err
  );

  modport slave (
    input  in_valid, in_data, in_sel, auto, out_ready,
    output in_ready, out_valid, out_data, err
  );

endinterface

// File: rtl/demux_fifo2.sv
// Two-entry FIFO used as the per-channel output buffer.
//   clk_i, rst_i : clock, synchronous active-high reset (storage itself is not reset)
//   push_i       : write wdata_i (ignored when full)
//   pop_i        : drop the head entry (ignored when empty)
//   full_o       : two entries held
//   empty_o      : no entry held
//   head_o       : oldest entry, stable until popped
module demux_fifo2
  import stream_demux_pkg::*;
#(
  parameter int unsigned W = DefaultW
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  cnt_t         cnt_q;
  cnt_t         cnt_d;
  logic         do_push;
  logic         do_pop;

  assign full_o  = (cnt_q == FifoDepth);
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && !full_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Simultaneous push and pop leaves the count unchanged.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/stream_demux.sv
// One-to-N stream demultiplexer with a 2-entry buffer per channel.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : stream_demux_if slave port (input beat, per-channel outputs, err)
// The destination is in_sel, or the internal round-robin pointer when auto = 1.
// A manual destination >= N is accepted and dropped, pulsing err the next cycle.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int unsigned N = DefaultN,
  parameter int unsigned W = DefaultW
) (
  input  logic           clk,
  input  logic           rst,
  stream_demux_if.slave  bus
);

  localparam int unsigned SelW = $clog2(N);

  logic [SelW-1:0] target;
  logic [SelW-1:0] rr_q;
  logic [SelW-1:0] rr_d;
  logic            tgt_valid;
  logic            tgt_full;
  logic            accept;
  logic            err_q;
  logic [N-1:0]    push;
  logic [N-1:0]    pop;
  logic [N-1:0]    full;
  logic [N-1:0]    empty;
  logic [W-1:0]    head [N];

  assign target    = bus.auto ? rr_q : bus.in_sel;
  assign tgt_valid = (32'(target) < N);

  // full[] is registered inside the FIFOs, so in_ready never sees out_ready.
  always_comb begin
    tgt_full = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (target == SelW'(i)) tgt_full = full[i];
    end
  end

  assign bus.in_ready = !tgt_valid || !tgt_full;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    rr_d = rr_q;
    if (accept && bus.auto) begin
      rr_d = (rr_q == SelW'(N - 1)) ? '0 : rr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q  <= '0;
      err_q <= 1'b0;
    end else begin
      rr_q  <= rr_d;
      err_q <= accept && !tgt_valid;
    end
  end

  assign bus.err = err_q;

  for (genvar i = 0; i < N; i++) begin : g_ch
    assign push[i] = accept && tgt_valid && (target == SelW'(i));
    assign pop[i]  = !empty[i] && bus.out_ready[i];

    demux_fifo2 #(
      .W (W)
    ) u_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (push[i]),
      .pop_i   (pop[i]),
      .wdata_i (bus.in_data),
      .full_o  (full[i]),
      .empty_o (empty[i]),
      .head_o  (head[i])
    );
  end

  assign bus.out_valid = ~empty;
  assign bus.out_data  = head;

endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 Parameter N, default 4, number of output channels (N >= 2, need not be a power of two).
REQ-002 Parameter W, default 8, data width in bits.
REQ-003 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, reset; synchronous and active-high.
REQ-005 Port in_valid, input, 1, an input beat is offered.
REQ-006 Port in_ready, output, 1, the block can accept the offered beat.
REQ-007 Port in_data, input, W, payload of the input beat.
REQ-008 Port in_sel, input, $clog2(N), destination channel when auto = 0.
REQ-009 Port auto, input, 1, selects the internal round-robin pointer instead of in_sel.
REQ-010 Port out_valid, output, N, per-channel beat available.
REQ-011 Port out_ready, input, N, per-channel consumer accepts.
REQ-012 Port out_data, output, unpacked array [N] of W bits, per-channel payload.
REQ-013 Port err, output, 1, one-cycle pulse when a beat addressed to a non-existent channel is dropped.

Function
REQ-014 Target channel: rr_ptr when auto = 1; otherwise in_sel.
REQ-015 Transfers: input accept = in_valid && in_ready; channel pop = out_valid[i] && out_ready[i].
REQ-016 Each channel has a 2-entry FIFO holding a count of 0..2; out_valid[i] = (count[i] != 0); out_data[i] = FIFO head, held stable while out_valid[i] && !out_ready[i].
REQ-017 Valid target: in_ready = (count[target] < 2); no combinational path from out_ready to in_ready.
REQ-018 Invalid target (in_sel >= N with auto = 0): in_ready = 1, beat dropped, no FIFO changes, err = 1 on the following cycle only.
REQ-019 Latency: a beat accepted in cycle t drives out_valid of its channel in cycle t+1 at the earliest.
REQ-020 Ordering: per-channel order is preserved; no beat is duplicated; no beat is lost except under REQ-018.
REQ-021 Push and pop on the same channel in the same cycle at count 1: count stays 1 and the new beat becomes head on the next cycle.
REQ-022 Push and pop on the same channel at count 2: cannot occur, because in_ready = 0.
REQ-023 Pops on several channels in one cycle are independent; at most one push occurs per cycle.
REQ-024 rr_ptr increments only on an accept while auto = 1, and wraps from N-1 to 0.
REQ-025 rr_ptr holds its value while auto = 0 or no accept occurs.
REQ-026 Toggling auto takes effect on target selection combinationally in the same cycle.
REQ-027 Stall: when the round-robin target is full, in_ready = 0 and rr_ptr holds; no channel is skipped.
REQ-028 When in_valid = 0, in_ready still reflects the current target's state.

Reset
REQ-029 While rst = 1 on a clock edge: all counts = 0, FIFO pointers = 0, rr_ptr = 0, err = 0.
REQ-030 Outputs after reset: out_valid = '0; in_ready = 1 for any valid target.
REQ-031 Reset mid-operation discards all buffered beats; no out_valid is asserted in the cycle after reset.
REQ-032 FIFO data storage is not reset; out_data is don't-care while out_valid = 0.

Structure
REQ-033 Package stream_demux_pkg shall hold the default N and W constants, the channel-index typedef, and the count typedef (2 bits).
REQ-034 Sub-module demux_fifo2 (2-entry FIFO with push, pop, full, empty, head) shall be instantiated N times through a generate loop.
REQ-035 Target decode, in_ready, rr_ptr and err logic shall reside in the top level.

Verification
REQ-036 Manual routing: auto = 0; send 0x11, 0x22, 0x33, 0x44 to channels 0..3 with all out_ready = 1. Each appears on its channel one cycle after accept, and in_ready stays 1.
REQ-037 Backpressure: out_ready[2] = 0; send 0xA0, 0xA1, 0xA2 to channel 2. The first two are accepted, in_ready = 0 on the third. Raising out_ready[2] pops 0xA0 then 0xA1, then 0xA2 is accepted.
REQ-038 Round-robin: auto = 1; 9 consecutive beats 0..8 land on channels 0,1,2,3,0,1,2,3,0, and rr_ptr = 1 at the end.
REQ-039 Round-robin stall: auto = 1 with channel 1 full. in_ready = 0 and rr_ptr holds at 1 until channel 1 pops, then the next beat goes to channel 1.
REQ-040 Invalid select: N = 3, auto = 0, in_sel = 3, in_valid = 1. The beat is accepted, err pulses for exactly one cycle, and no out_valid is asserted.
REQ-041 Reset flush: fill channel 0 to count 2, assert rst for one cycle. Then out_valid = 0, rr_ptr = 0, and the next beat to channel 0 appears alone.
